// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_3to8_hold registered decoder.
package dec_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;

    typedef enum logic {
        DEC_IDLE = 1'b0,
        DEC_HOLD = 1'b1
    } dec_state_e;

    function automatic logic [OUT_W-1:0] onehot8(input logic [CODE_W-1:0] code);
        logic [OUT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dec_3to8_comb.sv
// Pure combinational 3-to-8 one-hot decode; zero forces all lines low.
module dec_3to8_comb
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              zero,
    output logic [OUT_W-1:0]  y
);

    always_comb begin
        y = '0;
        if (!zero) begin
            y = onehot8(code);
        end
    end

endmodule

// File: rtl/dec_3to8_hold.sv
// Registered 3-to-8 decoder: each accepted code drives its line for HOLD_CYCLES
// cycles, then one all-zero cycle with a done pulse. Optional one-entry input
// buffer enabled with macro DEC_3TO8_QUEUE_EN.
//
// state    | meaning
// DEC_IDLE | outputs zero, ready to load a new code
// DEC_HOLD | decoded line driven, hold counter running down
module dec_3to8_hold
    import dec_pkg::*;
#(
    parameter  int HOLD_CYCLES = 4,
    localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CODE_W-1:0] in_code,
    input  logic             in_zero,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic             y0,
    output logic             y1,
    output logic             y2,
    output logic             y3,
    output logic             y4,
    output logic             y5,
    output logic             y6,
    output logic             y7,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    dec_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             done_q, done_d;

    logic [CODE_W-1:0] src_code;
    logic              src_zero;
    logic [OUT_W-1:0]  dec_y;
    logic              xfer;

    assign xfer = in_vld && in_rdy;

`ifdef DEC_3TO8_QUEUE_EN
    logic              buf_full_q, buf_full_d;
    logic [CODE_W-1:0] buf_code_q, buf_code_d;
    logic              buf_zero_q, buf_zero_d;

    assign in_rdy   = rst_n && !buf_full_q;
    // A full buffer always wins over the live input when loading y.
    assign src_code = buf_full_q ? buf_code_q : in_code;
    assign src_zero = buf_full_q ? buf_zero_q : in_zero;
`else
    assign in_rdy   = rst_n && (state_q == DEC_IDLE);
    assign src_code = in_code;
    assign src_zero = in_zero;
`endif

    dec_3to8_comb u_comb (
        .code (src_code),
        .zero (src_zero),
        .y    (dec_y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
`ifdef DEC_3TO8_QUEUE_EN
        buf_full_d = buf_full_q;
        buf_code_d = buf_code_q;
        buf_zero_d = buf_zero_q;
`endif
        case (state_q)
            DEC_IDLE: begin
`ifdef DEC_3TO8_QUEUE_EN
                if (buf_full_q || xfer) begin
                    y_d        = dec_y;
                    cnt_d      = CNT_LOAD;
                    state_d    = DEC_HOLD;
                    buf_full_d = 1'b0;
                end
`else
                if (xfer) begin
                    y_d     = dec_y;
                    cnt_d   = CNT_LOAD;
                    state_d = DEC_HOLD;
                end
`endif
            end
            DEC_HOLD: begin
                if (cnt_q == '0) begin
                    y_d     = '0;
                    done_d  = 1'b1;
                    state_d = DEC_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`ifdef DEC_3TO8_QUEUE_EN
                if (xfer) begin
                    buf_full_d = 1'b1;
                    buf_code_d = in_code;
                    buf_zero_d = in_zero;
                end
`endif
            end
            default: begin
                state_d = DEC_IDLE;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DEC_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

`ifdef DEC_3TO8_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full_q <= 1'b0;
            buf_code_q <= '0;
            buf_zero_q <= 1'b0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_code_q <= buf_code_d;
            buf_zero_q <= buf_zero_d;
        end
    end
`endif

    assign {y7, y6, y5, y4, y3, y2, y1, y0} = y_q;
    assign busy = (state_q == DEC_HOLD);
    assign done = done_q;

endmodule

// File: tb/tb_dec_3to8_hold.sv
// Self-checking bench for dec_3to8_hold (HOLD_CYCLES=4 and =1 instances) against
// a transaction-level model; honours DEC_3TO8_QUEUE_EN.
module tb_dec_3to8_hold;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       in_zero = 1'b0;
    logic       in_vld = 1'b0;
    logic       sel1 = 1'b0;

    logic rdy_a, busy_a, done_a, rdy_b, busy_b, done_b;
    logic a0, a1, a2, a3, a4, a5, a6, a7;
    logic b0, b1, b2, b3, b4, b5, b6, b7;

    always #5 clk = ~clk;

    dec_3to8_hold #(.HOLD_CYCLES(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_zero(in_zero),
        .in_vld(in_vld), .in_rdy(rdy_a),
        .y0(a0), .y1(a1), .y2(a2), .y3(a3), .y4(a4), .y5(a5), .y6(a6), .y7(a7),
        .busy(busy_a), .done(done_a)
    );

    dec_3to8_hold #(.HOLD_CYCLES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .in_code(in_code), .in_zero(in_zero),
        .in_vld(in_vld), .in_rdy(rdy_b),
        .y0(b0), .y1(b1), .y2(b2), .y3(b3), .y4(b4), .y5(b5), .y6(b6), .y7(b7),
        .busy(busy_b), .done(done_b)
    );

    logic [2:0] tc_code;
    logic       tc_zero;
    logic [7:0] tc_y;

    dec_3to8_comb u_comb_ref (.code(tc_code), .zero(tc_zero), .y(tc_y));

    logic [7:0] obs_y;
    logic       obs_busy, obs_done, obs_rdy;
    assign obs_y    = sel1 ? {b7, b6, b5, b4, b3, b2, b1, b0} : {a7, a6, a5, a4, a3, a2, a1, a0};
    assign obs_busy = sel1 ? busy_b : busy_a;
    assign obs_done = sel1 ? done_b : done_a;
    assign obs_rdy  = sel1 ? rdy_b  : rdy_a;

    int nvec  = 0;
    int nfail = 0;

    // Model: an item is visible for H cycles, then one zero/done cycle.
    int         m_hi;
    logic [7:0] m_cur;
    logic       m_gap;
    logic [7:0] m_q[$];
    logic [7:0] e_y;
    logic       e_busy, e_done, e_rdy;
    logic [7:0] s_y;
    logic       s_busy, s_done, s_rdy, s_acc;

    function automatic logic [7:0] ref_line(input logic [2:0] code, input logic zero);
        logic [7:0] one;
        one = 8'h01;
        return zero ? 8'h00 : (one << code);
    endfunction

    task automatic model_clear();
        m_hi  = 0;
        m_cur = 8'h00;
        m_gap = 1'b0;
        m_q.delete();
    endtask

    task automatic model_outputs();
        e_y    = (m_hi > 0) ? m_cur : 8'h00;
        e_busy = (m_hi > 0);
        e_done = m_gap;
`ifdef DEC_3TO8_QUEUE_EN
        e_rdy  = (m_q.size() == 0);
`else
        e_rdy  = (m_hi == 0);
`endif
    endtask

    task automatic model_edge(input logic acc, input logic [7:0] item);
        int h;
        h = sel1 ? 1 : 4;
        if (m_hi > 0) begin
            m_hi  = m_hi - 1;
            m_gap = (m_hi == 0);
            if (acc) m_q.push_back(item);
        end else begin
            m_gap = 1'b0;
            if (m_q.size() > 0) begin
                m_cur = m_q.pop_front();
                m_hi  = h;
            end else if (acc) begin
                m_cur = item;
                m_hi  = h;
            end
        end
    endtask

    // Samples DUT at the falling edge, then advances the model across the rising edge.
    task automatic tick();
        logic [7:0] item;
        @(negedge clk);
        model_outputs();
        s_y    = obs_y;
        s_busy = obs_busy;
        s_done = obs_done;
        s_rdy  = obs_rdy;
        s_acc  = in_vld && e_rdy;
        item   = ref_line(in_code, in_zero);
        @(posedge clk);
        model_edge(s_acc, item);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        in_zero = 1'b0;
        rst_n   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_comb();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) begin
            tc_code = 3'(i % 8);
            tc_zero = (i >= 8);
            #1;
            exp = ref_line(tc_code, tc_zero);
            nvec++;
            if (tc_y !== exp) begin
                nfail++;
                $display("FAIL comb code=%0d zero=%0b: got %h exp %h", tc_code, tc_zero, tc_y, exp);
            end
        end
    endtask

    task automatic test_reset();
        sel1  = 1'b0;
        rst_n = 1'b0;
        #3;
        nvec += 4;
        if (obs_y !== 8'h00) begin nfail++; $display("FAIL reset y: got %h exp 00", obs_y); end
        if (obs_busy !== 1'b0) begin nfail++; $display("FAIL reset busy: got %b exp 0", obs_busy); end
        if (obs_done !== 1'b0) begin nfail++; $display("FAIL reset done: got %b exp 0", obs_done); end
        if (obs_rdy !== 1'b0) begin nfail++; $display("FAIL reset in_rdy: got %b exp 0", obs_rdy); end
        do_reset();
        tick();
        nvec++;
        if (s_rdy !== 1'b1) begin nfail++; $display("FAIL reset release in_rdy: got %b exp 1", s_rdy); end
    endtask

    task automatic test_single();
        int hi_cnt;
        sel1 = 1'b0;
        do_reset();
        in_code = 3'd5;
        in_vld  = 1'b1;
        hi_cnt  = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            in_vld = 1'b0;
            if (s_y == 8'h20) hi_cnt++;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL single c%0d y: got %h exp %h", c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL single c%0d busy: got %b exp %b", c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL single c%0d done: got %b exp %b", c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL single c%0d in_rdy: got %b exp %b", c, s_rdy, e_rdy); end
        end
        nvec++;
        if (hi_cnt != 4) begin nfail++; $display("FAIL single y5 high cycles: got %0d exp 4", hi_cnt); end
    endtask

    task automatic test_sweep();
        int code;
        int guard;
        sel1 = 1'b0;
        do_reset();
        code   = 0;
        guard  = 0;
        in_vld = 1'b1;
        while (code < 8 && guard < 80) begin
            in_code = 3'(code);
            tick();
            guard++;
            if (s_acc) code++;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL sweep y: got %h exp %h", s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL sweep busy: got %b exp %b", s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL sweep done: got %b exp %b", s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL sweep in_rdy: got %b exp %b", s_rdy, e_rdy); end
        end
        in_vld = 1'b0;
        nvec++;
        if (code != 8) begin nfail++; $display("FAIL sweep accepted codes: got %0d exp 8", code); end
        for (int c = 0; c < 6; c++) begin
            tick();
            nvec += 2;
            if (s_y !== e_y) begin nfail++; $display("FAIL sweep tail y: got %h exp %h", s_y, e_y); end
            if (s_done !== e_done) begin nfail++; $display("FAIL sweep tail done: got %b exp %b", s_done, e_done); end
        end
    endtask

    task automatic test_zero();
        sel1 = 1'b0;
        do_reset();
        in_code = 3'd6;
        in_zero = 1'b1;
        in_vld  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            in_vld  = 1'b0;
            in_zero = 1'b0;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL zero c%0d y: got %h exp %h", c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL zero c%0d busy: got %b exp %b", c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL zero c%0d done: got %b exp %b", c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL zero c%0d in_rdy: got %b exp %b", c, s_rdy, e_rdy); end
        end
    endtask

    task automatic test_reset_mid_hold();
        sel1 = 1'b0;
        do_reset();
        in_code = 3'd3;
        in_vld  = 1'b1;
        tick();
        in_vld = 1'b0;
        tick();
        tick();
        #2;
        nvec++;
        if (obs_y !== 8'h08) begin nfail++; $display("FAIL midrst pre y: got %h exp 08", obs_y); end
        rst_n = 1'b0;
        #1;
        nvec += 4;
        if (obs_y !== 8'h00) begin nfail++; $display("FAIL midrst y: got %h exp 00", obs_y); end
        if (obs_busy !== 1'b0) begin nfail++; $display("FAIL midrst busy: got %b exp 0", obs_busy); end
        if (obs_done !== 1'b0) begin nfail++; $display("FAIL midrst done: got %b exp 0", obs_done); end
        if (obs_rdy !== 1'b0) begin nfail++; $display("FAIL midrst in_rdy: got %b exp 0", obs_rdy); end
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
        in_code = 3'd1;
        in_vld  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            in_vld = 1'b0;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL midrst after c%0d y: got %h exp %h", c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL midrst after c%0d busy: got %b exp %b", c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL midrst after c%0d done: got %b exp %b", c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL midrst after c%0d in_rdy: got %b exp %b", c, s_rdy, e_rdy); end
        end
    endtask

    task automatic test_hold1();
        int idx;
        sel1 = 1'b1;
        do_reset();
        idx    = 0;
        in_vld = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_code = (idx == 0) ? 3'd1 : 3'd2;
            in_vld  = (idx < 2);
            tick();
            if (s_acc) idx++;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL hold1 c%0d y: got %h exp %h", c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL hold1 c%0d busy: got %b exp %b", c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL hold1 c%0d done: got %b exp %b", c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL hold1 c%0d in_rdy: got %b exp %b", c, s_rdy, e_rdy); end
        end
        in_vld = 1'b0;
    endtask

`ifdef DEC_3TO8_QUEUE_EN
    task automatic test_queue();
        int   idx;
        logic seen4;
        logic [2:0] codes [3];
        codes[0] = 3'd2;
        codes[1] = 3'd7;
        codes[2] = 3'd4;
        sel1  = 1'b0;
        do_reset();
        idx   = 0;
        seen4 = 1'b0;
        for (int c = 0; c < 24; c++) begin
            in_vld  = (idx < 3);
            in_code = codes[(idx < 3) ? idx : 2];
            tick();
            if (s_acc) idx++;
            if (s_y == 8'h10) seen4 = 1'b1;
            nvec += 4;
            if (s_y !== e_y) begin nfail++; $display("FAIL queue c%0d y: got %h exp %h", c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL queue c%0d busy: got %b exp %b", c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL queue c%0d done: got %b exp %b", c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL queue c%0d in_rdy: got %b exp %b", c, s_rdy, e_rdy); end
        end
        in_vld = 1'b0;
        nvec++;
        if (seen4 !== 1'b1) begin nfail++; $display("FAIL queue third item shown: got %b exp 1", seen4); end
    endtask
`endif

    task automatic test_random(input logic use_h1, input int cycles);
        sel1 = use_h1;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            in_vld  = ($urandom_range(0, 1) == 1);
            in_code = 3'($urandom_range(0, 7));
            in_zero = ($urandom_range(0, 7) == 0);
            tick();
            nvec += 5;
            if (s_y !== e_y) begin nfail++; $display("FAIL random h1=%0b c%0d y: got %h exp %h", use_h1, c, s_y, e_y); end
            if (s_busy !== e_busy) begin nfail++; $display("FAIL random h1=%0b c%0d busy: got %b exp %b", use_h1, c, s_busy, e_busy); end
            if (s_done !== e_done) begin nfail++; $display("FAIL random h1=%0b c%0d done: got %b exp %b", use_h1, c, s_done, e_done); end
            if (s_rdy !== e_rdy) begin nfail++; $display("FAIL random h1=%0b c%0d in_rdy: got %b exp %b", use_h1, c, s_rdy, e_rdy); end
            if ($countones(s_y) > 1) begin nfail++; $display("FAIL random onehot: got %h exp at most one bit", s_y); end
        end
        in_vld  = 1'b0;
        in_zero = 1'b0;
    endtask

    initial begin
        model_clear();
        test_comb();
        test_reset();
        test_single();
        test_sweep();
        test_zero();
        test_reset_mid_hold();
        test_hold1();
`ifdef DEC_3TO8_QUEUE_EN
        test_queue();
`endif
        test_random(1'b0, 400);
        test_random(1'b1, 200);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dec_3to8_hold.md
Name: dec_3to8_hold

Overview:
- Registered 3-to-8 decoder, the inverse of the enc_8to3 priority encoder: a 3-bit code maps to one-hot lines y7..y0.
- Each accepted code drives its one-hot output for a programmable hold time, then returns all lines to zero.
- Break-before-make is guaranteed: at least one all-zero cycle between consecutive codes.
- Sits between control logic issuing select codes and downstream enable/strobe lines.

Parameters:
- HOLD_CYCLES, 4, number of cycles a decoded line stays high; legal range 1..255.
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width; derived, not overridden.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_code  input  3  code to decode; bit 2 is MSB
- in_zero  input  1  when set with in_code, the accepted item drives all outputs zero for the hold time; models the encoder's 0000_0000 input
- in_vld  input  1  in_code/in_zero valid
- in_rdy  output  1  block can accept; transfer occurs when in_vld && in_rdy at a rising edge
- y0..y7  output  1 each  decoded one-hot lines; yN high when code==N and in_zero==0
- busy  output  1  high while in HOLD
- done  output  1  single-cycle pulse in the cycle outputs return to zero after a hold

Behaviour:
- Reset (async, rst_n low): y0..y7=0, busy=0, done=0, state=IDLE, cnt=0, queue empty. in_rdy is forced 0 while rst_n is low and is 1 in the first cycle after release.
- States:
  - IDLE: in_rdy=1 (queue empty).
  - HOLD: busy=1.
- IDLE, transfer at edge E:
  - After E: y = onehot(in_code), or all-zero if in_zero.
  - state=HOLD, cnt=HOLD_CYCLES-1.
  - Latency from accepting edge to visible output is 1 cycle.
- HOLD, cnt!=0: cnt decrements each edge; y is unchanged.
- HOLD, edge with cnt==0: y cleared to zero, done=1 for the following cycle, state=IDLE.
- Output timing:
  - Outputs are high for exactly HOLD_CYCLES cycles.
  - done is a registered pulse, coincident with the first all-zero cycle.
- Without the queue, in_rdy=0 throughout HOLD. Input held during HOLD is ignored and is not consumed.
- in_code is never X-propagated into y: decode only on transfer.
- At most one y line is high at any time.
- HOLD_CYCLES=1: y is high for one cycle, then IDLE. Back-to-back codes give the pattern high, zero, high…
- Reset asserted mid-HOLD: immediate clear of all outputs; no done pulse.

Optional Feature:
- Macro: DEC_3TO8_QUEUE_EN.
- Defined: adds a one-entry holding buffer.
  - in_rdy = rst_n && !buf_full. An item can be accepted during HOLD; it fills the buffer.
  - On the cnt==0 edge, y is still cleared and state goes to IDLE (one zero cycle).
  - In IDLE with buf_full, the buffer loads to y at the next edge and the buffer empties. Buffer content has priority over in_vld; in_rdy=0 while the buffer is full.
  - Transfer in IDLE with buffer empty bypasses the buffer directly to y.
- Undefined: no buffer, and in_rdy = rst_n && (state==IDLE).

Decomposition:
- Package dec_pkg:
  - CODE_W=3, OUT_W=8.
  - state enum {DEC_IDLE, DEC_HOLD}.
  - function onehot8(code) returning 8-bit one-hot.
- Sub-module dec_3to8_comb: pure combinational code+zero to 8-bit one-hot. Reused by the bench as golden model.
- Top handles the FSM, counter, queue and done.

Test Plan:
- Reset then in_code=3'd5, in_vld one cycle -> y5=1 for exactly 4 cycles starting 1 cycle after the accept edge, busy=1 during that time, then all y=0 and done=1 for 1 cycle.
- Sweep codes 0..7 with in_vld held high, HOLD_CYCLES=4 -> each yN high 4 cycles, one zero cycle between, in_rdy low during HOLD. The {y7..y0} sequence is 01,02,04,...,80 and re-encodes via enc_8to3 to 0..7.
- in_zero=1, in_code=3'd6 -> all y=0 for 4 cycles, busy=1, done pulses after 4 cycles.
- rst_n low at hold cycle 2 of code 3 -> y3 drops immediately; no done; in_rdy=1 the first cycle after release; next code accepted normally.
- HOLD_CYCLES=1 with continuous in_vld, codes 1,2 -> y1 high 1 cycle, zero 1 cycle, y2 high 1 cycle.
- DEC_3TO8_QUEUE_EN: send 2 then 7 during HOLD -> 7 buffered, in_rdy=0 while full. y2 4 cycles, then 1 zero cycle, then y7 4 cycles; a third item offered while full is stalled, not dropped.
